// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// The master side presents operands and takes results. The slave side is the divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             src_valid;
    logic             src_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             dest_valid;
    logic             dest_ready;

    modport master (
        output dividend, divisor, src_valid, dest_ready,
        input  src_ready, quotient, remainder, div_by_zero, dest_valid
    );

    modport slave (
        input  dividend, divisor, src_valid, dest_ready,
        output src_ready, quotient, remainder, div_by_zero, dest_valid
    );
endinterface

// File: rtl/seq_divider.sv
// Signed radix-2 restoring divider with C truncation semantics and fixed WIDTH-cycle latency.
// Results are held until the sink accepts them.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int unsigned W1   = WIDTH + 1;
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [W1-1:0]    dvs_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic             zero_q;

    logic             src_ready_q;
    logic             dest_valid_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH-1:0] dvd_mag;
    logic [W1-1:0]    dvs_ext;
    logic [W1-1:0]    dvs_mag;
    logic [W1-1:0]    shifted;
    logic [WIDTH-1:0] sub;
    logic             ge;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // The dividend magnitude (at most 2^(WIDTH-1)) fits WIDTH unsigned bits.
    // The divisor is widened by one bit so the trial compare stays unsigned.
    always_comb begin
        dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        dvs_ext = {bus.divisor[WIDTH-1], bus.divisor};
        dvs_mag = bus.divisor[WIDTH-1] ? (~dvs_ext + W1'(1)) : dvs_ext;
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge      = (shifted >= dvs_q);
        sub     = WIDTH'(shifted - dvs_q);
        rem_nxt = ge ? sub : shifted[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], ge};
        // The overflow case wraps naturally: a magnitude of 2^(WIDTH-1) with a positive sign.
        quo_fix = zero_q ? '1 : (quo_neg_q ? (~quo_nxt + WIDTH'(1)) : quo_nxt);
        rem_fix = rem_neg_q ? (~rem_nxt + WIDTH'(1)) : rem_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            quo_neg_q     <= 1'b0;
            rem_neg_q     <= 1'b0;
            zero_q        <= 1'b0;
            src_ready_q   <= 1'b0;
            dest_valid_q  <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    src_ready_q <= 1'b1;
                    if (bus.src_valid && src_ready_q) begin
                        state_q     <= StCalc;
                        src_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        quo_q       <= dvd_mag;
                        rem_q       <= '0;
                        dvs_q       <= dvs_mag;
                        quo_neg_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        rem_neg_q   <= bus.dividend[WIDTH-1];
                        zero_q      <= (bus.divisor == '0);
                    end
                end
                StCalc: begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q       <= StDone;
                        dest_valid_q  <= 1'b1;
                        quotient_q    <= quo_fix;
                        remainder_q   <= rem_fix;
                        div_by_zero_q <= zero_q;
                    end
                end
                StDone: begin
                    if (bus.dest_ready) begin
                        state_q      <= StIdle;
                        dest_valid_q <= 1'b0;
                        src_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    src_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.src_ready   = src_ready_q;
    assign bus.dest_valid  = dest_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: doc/seq_divider.md
# seq_divider

Signed sequential integer divider using the same valid/ready handshake as `seq_multiplier`; it completes the arithmetic pair in the datapath. A source presents dividend/divisor with `src_valid`. The block runs a radix-2 restoring division over magnitudes, one quotient bit per cycle. It presents quotient/remainder with `dest_valid` and holds them until the sink takes them with `dest_ready`.

## Interface
- `WIDTH`, 16, operand and result width in bits, two's complement; legal range 2..32
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `dividend`  in  WIDTH  signed dividend; sampled only on the input handshake
- `divisor`  in  WIDTH  signed divisor; sampled only on the input handshake
- `src_valid`  in  1  source has operands
- `src_ready`  out  1  divider can accept operands
- `quotient`  out  WIDTH  signed quotient
- `remainder`  out  WIDTH  signed remainder
- `div_by_zero`  out  1  current result came from divisor == 0
- `dest_valid`  out  1  result is valid
- `dest_ready`  in  1  sink accepts the result

## Operation
- FSM states:
  - IDLE: `src_ready`=1.
  - CALC: WIDTH iterations, counted by a bit counter.
  - DONE: `dest_valid`=1.
- IDLE -> CALC on `src_valid & src_ready` at a rising edge. At that edge the block registers:
  - |dividend| and |divisor|,
  - result sign = sign(dividend) XOR sign(divisor),
  - remainder sign = sign(dividend),
  - zero-divisor flag.
- Magnitudes use WIDTH+1-bit internal width, so |−2^(WIDTH−1)| is exact.
- CALC iteration: shift {partial remainder, dividend magnitude} left by 1; trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
- CALC -> DONE at the edge completing iteration WIDTH. That same edge registers the sign-corrected outputs:
  - Truncation toward zero; the remainder takes the sign of the dividend (C semantics).
  - Divisor 0: quotient = all ones (−1), remainder = dividend, `div_by_zero`=1. The iterations still run, so latency is fixed.
  - Overflow (−2^(WIDTH−1) / −1): quotient = −2^(WIDTH−1) (wraps), remainder = 0, `div_by_zero`=0.
  - Otherwise `div_by_zero`=0.
- DONE -> IDLE on `dest_valid & dest_ready` at a rising edge.
- `quotient`, `remainder` and `div_by_zero` hold their last values until the next DONE load.
- No overlap: `src_ready`=0 throughout CALC and DONE. A new operand cannot be accepted in the same cycle as the output handshake.
- `src_valid` in CALC/DONE and `dest_ready` in IDLE/CALC are ignored.
- Operand inputs may change freely after acceptance without affecting the result.

## Timing
- Reset (`rst_n`=0, asynchronous, any time, including mid-CALC or mid-DONE) forces immediately:
  - state = IDLE, counter = 0;
  - `dest_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0;
  - `src_ready`=0 while `rst_n` is low, 1 from the first cycle after release.
- An in-flight operation is discarded with no result.
- Latency: input handshake at edge E0 -> `dest_valid` high after edge E(WIDTH). That is WIDTH cycles (16 by default), independent of operand values.
- `dest_valid` stays high, with outputs stable, for as long as `dest_ready` is low.
- `src_ready` rises the cycle after the output handshake edge.
- Minimum throughput: one result per WIDTH+2 cycles when `src_valid` and `dest_ready` are held high.
- All outputs are registered or decoded from state only; no combinational path from `src_valid`/`dest_ready` to any output.

## Test plan
- 100 / 7 -> `quotient`=14, `remainder`=2, `div_by_zero`=0. `dest_valid` rises exactly 16 cycles after the input handshake.
- Signs (WIDTH=16):
  - −100 / 7 -> −14, −2.
  - 100 / −7 -> −14, 2.
  - −100 / −7 -> 14, −2.
  - −32768 / −1 -> −32768, 0.
  - 32767 / 1 -> 32767, 0.
- 5 / 0 -> `quotient`=0xFFFF, `remainder`=5, `div_by_zero`=1. The next operation, 9 / 3 -> 3, 0 with the flag cleared.
- Backpressure and protocol:
  - Hold `dest_ready`=0 for 10 cycles after `dest_valid` -> outputs and `dest_valid` stay stable; `src_ready` stays 0.
  - Toggle `src_valid` and the operands during CALC -> result unchanged; no second acceptance.
- Reset: assert `rst_n` low at cycle 8 of CALC -> `dest_valid`=0 and outputs 0 at once. After release, 81 / 9 -> 9, 0 with normal latency.
- Random: 100k signed operand pairs with random `src_valid` and `dest_ready` delays (0–9 cycles). Every result must match C-truncation reference division, with the zero and overflow rules applied.
